vga_scan_gen: RTL and testbench

//   Raster timing generator that drives the pixel coordinate bus (x, y) used by every

---
 rtl/vga_scan_gen_if.sv | 35 +++
 rtl/vga_scan_gen.sv | 117 +++++++++++
 tb/tb_vga_scan_gen.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/vga_scan_gen_if.sv
// ---------------------------------------------------------------------------
// vga_scan_gen_if
//   Raster scan bus produced by vga_scan_gen and consumed by the overlay and
//   text renderers.
//   Signals:
//     x, y         current pixel coordinate (h_cnt / v_cnt, not clamped)
//     video_on     coordinate lies inside the visible area
//     hsync/vsync  sync outputs at the configured polarity
//     pix_tick     last system clock of the current pixel period
//     line_start   one-clk strobe at the start of every line
//     frame_start  one-clk strobe at the start of every frame
//     frame_cnt    frames completed since reset (wraps)
//   Modports: master (generator drives), slave (renderers observe).
// ---------------------------------------------------------------------------
interface vga_scan_gen_if;
   logic [9:0] x;
   logic [9:0] y;
   logic       video_on;
   logic       hsync;
   logic       vsync;
   logic       pix_tick;
   logic       line_start;
   logic       frame_start;
   logic [7:0] frame_cnt;

   modport master (
      output x, y, video_on, hsync, vsync,
      output pix_tick, line_start, frame_start, frame_cnt
   );

   modport slave (
      input x, y, video_on, hsync, vsync,
      input pix_tick, line_start, frame_start, frame_cnt
   );
endinterface

// File: rtl/vga_scan_gen.sv
// ---------------------------------------------------------------------------
// vga_scan_gen
//   Raster timing generator. Divides clk down to the pixel rate, runs the
//   horizontal/vertical counters and decodes sync, blanking and line/frame
//   strobes for the renderers and game logic.
//   Ports:
//     clk      system clock, all state on the rising edge
//     reset    synchronous, active-high reset
//     scan_o   raster scan bus (vga_scan_gen_if.master)
// ---------------------------------------------------------------------------
module vga_scan_gen #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int CLK_DIV  = 4,
   parameter bit SYNC_POL = 1'b0
) (
   input  logic           clk,
   input  logic           reset,
   vga_scan_gen_if.master scan_o
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
   localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
   localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

   // A divide-by-1 still needs a one-bit counter that simply stays at zero.
   localparam int              DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
   logic [9:0]       h_cnt_q,   h_cnt_d;
   logic [9:0]       v_cnt_q,   v_cnt_d;
   logic             line_start_q,  line_start_d;
   logic             frame_start_q, frame_start_d;
   logic [7:0]       frame_cnt_q,   frame_cnt_d;

   logic pix_tick;
   logic h_last;
   logic v_last;

   // NOTE: every signal written here gets a default first so no path leaves it
   // unassigned; otherwise synthesis infers a latch.
   always_comb begin
      pix_tick  = (div_cnt_q == DIV_LAST);
      h_last    = (h_cnt_q == H_LAST);
      v_last    = (v_cnt_q == V_LAST);

      div_cnt_d = pix_tick ? '0 : div_cnt_q + DIV_W'(1);
      h_cnt_d   = h_cnt_q;
      v_cnt_d   = v_cnt_q;

      // Counters only move on the pixel tick and hold otherwise.
      if (pix_tick) begin
         if (h_last) begin
            h_cnt_d = '0;
            v_cnt_d = v_last ? '0 : v_cnt_q + 10'd1;
         end else begin
            h_cnt_d = h_cnt_q + 10'd1;
         end
      end

      // Strobes are registered, so they appear on the clk after the wrap.
      line_start_d  = pix_tick & h_last;
      frame_start_d = pix_tick & h_last & v_last;
      frame_cnt_d   = frame_cnt_q + {7'd0, frame_start_d};
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         // A strobe pending in the reset cycle is discarded here.
         div_cnt_q     <= '0;
         h_cnt_q       <= '0;
         v_cnt_q       <= '0;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
         frame_cnt_q   <= '0;
      end else begin
         div_cnt_q     <= div_cnt_d;
         h_cnt_q       <= h_cnt_d;
         v_cnt_q       <= v_cnt_d;
         line_start_q  <= line_start_d;
         frame_start_q <= frame_start_d;
         frame_cnt_q   <= frame_cnt_d;
      end
   end

   // Coordinate-derived outputs decode the counter registers directly, so all
   // of them change on the same clk edge.
   assign scan_o.x           = h_cnt_q;
   assign scan_o.y           = v_cnt_q;
   assign scan_o.video_on    = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
   assign scan_o.hsync       = ((h_cnt_q >= HS_FIRST) && (h_cnt_q <= HS_LAST)) ?
                               SYNC_POL : ~SYNC_POL;
   assign scan_o.vsync       = ((v_cnt_q >= VS_FIRST) && (v_cnt_q <= VS_LAST)) ?
                               SYNC_POL : ~SYNC_POL;
   assign scan_o.pix_tick    = pix_tick;
   assign scan_o.line_start  = line_start_q;
   assign scan_o.frame_start = frame_start_q;
   assign scan_o.frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_vga_scan_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_scan_gen
//   Directed bench for vga_scan_gen using three instances on one clock:
//     u_dflt  default 640x480 timing, CLK_DIV=4 (reset, line timing, mid-run reset)
//     u_med   default horizontal timing, 7-line frame, CLK_DIV=4 (frame timing)
//     u_tiny  H 8/1/2/1, V 4/1/1/1, CLK_DIV=1 (per-clk advance, frame_cnt wrap)
//   Outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_vga_scan_gen;

   logic clk;
   logic rst_a, rst_b, rst_c;

   int n_checks = 0;
   int n_errors = 0;

   vga_scan_gen_if if_a ();
   vga_scan_gen_if if_b ();
   vga_scan_gen_if if_c ();

   vga_scan_gen u_dflt (
      .clk    (clk),
      .reset  (rst_a),
      .scan_o (if_a)
   );

   vga_scan_gen #(
      .V_ACTIVE (4), .V_FP (1), .V_SYNC (1), .V_BP (1)
   ) u_med (
      .clk    (clk),
      .reset  (rst_b),
      .scan_o (if_b)
   );

   vga_scan_gen #(
      .H_ACTIVE (8), .H_FP (1), .H_SYNC (2), .H_BP (1),
      .V_ACTIVE (4), .V_FP (1), .V_SYNC (1), .V_BP (1),
      .CLK_DIV  (1)
   ) u_tiny (
      .clk    (clk),
      .reset  (rst_c),
      .scan_o (if_c)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // ------------------------------------------------------------------ default
   task automatic run_default();
      int n_tick, n_hs, hs_x, n_vo, vo_x, ls1, ls2, n_ls, n_fs, w, ls_seen;

      rst_a = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_x",           if_a.x, 0);
      check("rst_y",           if_a.y, 0);
      check("rst_video_on",    if_a.video_on, 1);
      check("rst_hsync",       if_a.hsync, 1);
      check("rst_vsync",       if_a.vsync, 1);
      check("rst_pix_tick",    if_a.pix_tick, 0);
      check("rst_line_start",  if_a.line_start, 0);
      check("rst_frame_start", if_a.frame_start, 0);
      check("rst_frame_cnt",   if_a.frame_cnt, 0);
      rst_a = 1'b0;

      n_tick = 0; n_hs = 0; hs_x = -1; n_vo = 0; vo_x = -1;
      ls1 = 0; ls2 = 0; n_ls = 0; n_fs = 0;
      for (int k = 1; k <= 6400; k++) begin
         @(negedge clk);
         if (k <= 3200) begin
            if (if_a.pix_tick) n_tick++;
            if (!if_a.hsync) begin
               if (n_hs == 0) hs_x = int'(if_a.x);
               n_hs++;
            end
            if (!if_a.video_on) begin
               if (n_vo == 0) vo_x = int'(if_a.x);
               n_vo++;
            end
         end
         if (if_a.line_start) begin
            if (n_ls == 0) ls1 = k;
            else if (n_ls == 1) ls2 = k;
            n_ls++;
         end
         if (if_a.frame_start) n_fs++;
      end
      check("line_pix_ticks",    n_tick, 800);
      check("line_hsync_clks",   n_hs, 384);
      check("line_hsync_x0",     hs_x, 656);
      check("line_blank_clks",   n_vo, 640);
      check("line_blank_x0",     vo_x, 640);
      check("line_start_first",  ls1, 3200);
      check("line_start_second", ls2, 6400);
      check("line_start_count",  n_ls, 2);
      check("no_frame_start",    n_fs, 0);
      check("y_after_2_lines",   if_a.y, 2);

      // Reset in the middle of a line.
      w = 0;
      while (if_a.x != 10'd300 && w < 4000) begin
         @(negedge clk);
         w++;
      end
      check("wait_x300", (w < 4000), 1);
      rst_a = 1'b1;
      @(negedge clk);
      rst_a = 1'b0;
      check("midrst_x",           if_a.x, 0);
      check("midrst_y",           if_a.y, 0);
      check("midrst_pix_tick",    if_a.pix_tick, 0);
      check("midrst_line_start",  if_a.line_start, 0);
      check("midrst_frame_start", if_a.frame_start, 0);
      ls_seen = 0;
      repeat (2) begin
         @(negedge clk);
         if (if_a.pix_tick || if_a.line_start || if_a.frame_start) ls_seen++;
      end
      check("midrst_quiet", ls_seen, 0);
      @(negedge clk);
      check("midrst_first_tick", if_a.pix_tick, 1);
      check("midrst_x_hold",     if_a.x, 0);

      // Reset in the very cycle that would launch a line_start.
      w = 0;
      while (!(if_a.pix_tick && if_a.x == 10'd799) && w < 4000) begin
         @(negedge clk);
         w++;
      end
      check("wait_line_end", (w < 4000), 1);
      rst_a = 1'b1;
      @(negedge clk);
      rst_a = 1'b0;
      check("drop_line_start", if_a.line_start, 0);
      check("drop_x",          if_a.x, 0);
      @(negedge clk);
      check("drop_line_start_late", if_a.line_start, 0);
   endtask

   // ------------------------------------------------------------------- medium
   task automatic run_medium();
      int fs_k, n_vs, vs_y, ls_at_fs;

      rst_b = 1'b1;
      repeat (3) @(negedge clk);
      rst_b = 1'b0;
      fs_k = 0; n_vs = 0; vs_y = -1; ls_at_fs = 0;
      for (int k = 1; k <= 22400; k++) begin
         @(negedge clk);
         if (!if_b.vsync) begin
            if (n_vs == 0) vs_y = int'(if_b.y);
            n_vs++;
         end
         if (if_b.frame_start && fs_k == 0) begin
            fs_k = k;
            ls_at_fs = int'(if_b.line_start);
         end
         if (k == 22399) check("frame_cnt_before", if_b.frame_cnt, 0);
      end
      check("frame_start_latency",  fs_k, 22400);
      check("frame_line_start_too", ls_at_fs, 1);
      check("vsync_clks",           n_vs, 3200);
      check("vsync_y0",             vs_y, 5);
      check("frame_cnt_after",      if_b.frame_cnt, 1);
      check("frame_wrap_xy",        {if_b.x, if_b.y}, 0);
   endtask

   // --------------------------------------------------------------------- tiny
   task automatic run_tiny();
      int n_ls, n_fs, bad_ls, bad_fs;

      rst_c = 1'b1;
      @(negedge clk);
      check("div1_rst_pix_tick", if_c.pix_tick, 1);
      repeat (2) @(negedge clk);
      rst_c = 1'b0;
      n_ls = 0; n_fs = 0; bad_ls = 0; bad_fs = 0;
      for (int k = 1; k <= 84 * 256; k++) begin
         @(negedge clk);
         if (k == 1) check("div1_x_step1", if_c.x, 1);
         if (k == 2) check("div1_x_step2", if_c.x, 2);
         if (if_c.line_start) n_ls++;
         if (if_c.frame_start) n_fs++;
         if (if_c.line_start  != (k % 12 == 0)) bad_ls++;
         if (if_c.frame_start != (k % 84 == 0)) bad_fs++;
         if (k == 84)       check("div1_frame_cnt_1",   if_c.frame_cnt, 1);
         if (k == 84 * 255) check("div1_frame_cnt_255", if_c.frame_cnt, 255);
      end
      check("div1_line_start_count",  n_ls, 1792);
      check("div1_frame_start_count", n_fs, 256);
      check("div1_line_start_period", bad_ls, 0);
      check("div1_frame_start_period", bad_fs, 0);
      check("div1_frame_cnt_wrap",    if_c.frame_cnt, 0);
   endtask

   initial begin
      rst_a = 1'b1;
      rst_b = 1'b1;
      rst_c = 1'b1;
      fork
         run_default();
         run_medium();
         run_tiny();
      join
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
